// File: rtl/tff_toggle_decoder.sv
// Recovers the toggle stream from a tff's q/qn pair: t_out 1 clk after a q edge (3 clk with INPUT_SYNC_EN),
// plus a wrapping toggle count, burst flag on runs of BURST_LEN toggles, and sticky q/qn complement error.
module tff_toggle_decoder #(
  parameter int CNT_W     = 8,
  parameter int BURST_LEN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             q_in,
  input  logic             qn_in,
  output logic             t_out,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             burst,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, BURST} state_t;

  localparam int RUN_W = $clog2(BURST_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(BURST_LEN);

  logic             q_s;
  logic             qn_s;
  logic             err_en;
  logic             q_prev;
  logic             tog;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_next;
  state_t           state;

`ifdef INPUT_SYNC_EN
  logic [1:0] q_sync;
  logic [1:0] qn_sync;
  logic [1:0] mask_cnt;

  // Both sync flops come out of reset as 0/0, which would look like a
  // complement fault, so err is held off until real samples arrive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_sync   <= 2'b00;
      qn_sync  <= 2'b00;
      mask_cnt <= 2'd2;
    end else begin
      q_sync  <= {q_sync[0], q_in};
      qn_sync <= {qn_sync[0], qn_in};
      if (mask_cnt != 2'd0) mask_cnt <= mask_cnt - 2'd1;
    end
  end

  assign q_s    = q_sync[1];
  assign qn_s   = qn_sync[1];
  assign err_en = (mask_cnt == 2'd0);
`else
  assign q_s    = q_in;
  assign qn_s   = qn_in;
  assign err_en = 1'b1;
`endif

  assign tog = q_s ^ q_prev;

  always_comb begin
    run_next = '0;
    if (!clr && tog) run_next = (run == RUN_MAX) ? run : run + RUN_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      q_prev     <= 1'b0;
      run        <= '0;
      t_out      <= 1'b0;
      toggle_cnt <= '0;
      burst      <= 1'b0;
      err        <= 1'b0;
    end else begin
      // q_prev tracks every sample, even under clr, so t_out stays truthful.
      q_prev <= q_s;
      t_out  <= tog;
      run    <= run_next;
      burst  <= (run_next == RUN_MAX);

      if (clr)      toggle_cnt <= '0;
      else if (tog) toggle_cnt <= toggle_cnt + CNT_W'(1);

      if (clr)                        err <= 1'b0;
      else if (err_en && q_s == qn_s) err <= 1'b1;

      case (state)
        IDLE:    if (!clr && tog) state <= RUN;
        RUN:     if (clr || !tog) state <= IDLE;
                 else if (run_next == RUN_MAX) state <= BURST;
        BURST:   if (clr || !tog) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tff_toggle_decoder.sv
// Bench for tff_toggle_decoder: per-cycle reference model plus directed loopback vectors.
module tb_tff_toggle_decoder;
  localparam int CNT_W = 2;
  localparam int BL    = 3;
`ifdef INPUT_SYNC_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  logic             clk   = 1'b0;
  logic             rst   = 1'b0;
  logic             clr   = 1'b0;
  logic             q_in  = 1'b1;
  logic             qn_in = 1'b0;
  logic             t_out;
  logic [CNT_W-1:0] toggle_cnt;
  logic             burst;
  logic             err;

  int n_chk  = 0;
  int n_pass = 0;

  tff_toggle_decoder #(.CNT_W(CNT_W), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .clr(clr), .q_in(q_in), .qn_in(qn_in),
    .t_out(t_out), .toggle_cnt(toggle_cnt), .burst(burst), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference model: unbounded run length, input delay line, sticky error.
  logic m_t    = 1'b0;
  logic m_prev = 1'b0;
  int   m_cnt  = 0;
  int   m_run  = 0;
  int   m_err  = 0;
  int   m_mask = 0;
  logic pq [0:1];
  logic pqn[0:1];
  logic sq, sqn;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t = 0; m_prev = 0; m_cnt = 0; m_run = 0; m_err = 0; m_mask = DLY;
      pq[0] = 0; pq[1] = 0; pqn[0] = 0; pqn[1] = 0;
    end else begin
      if (DLY == 0) begin
        sq = q_in; sqn = qn_in;
      end else begin
        sq = pq[1]; sqn = pqn[1];
        pq[1] = pq[0]; pqn[1] = pqn[0];
        pq[0] = q_in;  pqn[0] = qn_in;
      end
      m_t    = sq ^ m_prev;
      m_prev = sq;
      if (clr) begin
        m_cnt = 0; m_run = 0; m_err = 0;
      end else begin
        m_cnt = (m_cnt + int'(m_t)) % (1 << CNT_W);
        m_run = m_t ? m_run + 1 : 0;
        if (m_mask == 0 && sq == sqn) m_err = 1;
      end
      if (m_mask > 0) m_mask--;
    end
  end

  always @(negedge clk) begin
    check("model_t_out", t_out, m_t);
    check("model_cnt", toggle_cnt, m_cnt);
    check("model_burst", burst, m_run >= BL);
    check("model_err", err, m_err);
  end

  logic qv = 1'b1;

  task automatic tick(input logic q, input logic qn, input logic c);
    q_in = q; qn_in = qn; clr = c;
    @(posedge clk); #1;
  endtask

  task automatic tff(input logic t);
    if (t) qv = ~qv;
    tick(qv, ~qv, 1'b0);
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_t"}, t_out, 0);
    check({nm, "_cnt"}, toggle_cnt, 0);
    check({nm, "_burst"}, burst, 0);
    check({nm, "_err"}, err, 0);
  endtask

  int wrap_exp[5] = '{1, 2, 3, 0, 1};

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");

`ifndef INPUT_SYNC_EN
    rst = 1'b0;
    tick(1'b1, 1'b0, 1'b0);
    check("rel_t", t_out, 1);
    check("rel_cnt", toggle_cnt, 1);

    // toggle train
    tick(qv, ~qv, 1'b1);
    check("clr_cnt", toggle_cnt, 0);
    for (int i = 1; i <= 3; i++) begin
      tff(1'b1);
      check("train_t", t_out, 1);
      check("train_cnt", toggle_cnt, i);
      check("train_burst", burst, (i == 3) ? 1 : 0);
    end
    tff(1'b0);
    check("train_end_t", t_out, 0);
    check("train_end_burst", burst, 0);

    // counter wrap
    tick(qv, ~qv, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tff(1'b1);
      check("wrap_cnt", toggle_cnt, wrap_exp[i]);
    end
    tff(1'b0);

    // complement fault
    tick(qv, qv, 1'b0);
    check("fault_err", err, 1);
    check("fault_t", t_out, 0);
    tff(1'b0);
    tff(1'b1);
    check("fault_sticky", err, 1);
    tick(qv, ~qv, 1'b1);
    check("fault_clr_err", err, 0);
    check("fault_clr_cnt", toggle_cnt, 0);

    // clear colliding with a toggle
    tff(1'b1);
    check("coll_pre_cnt", toggle_cnt, 1);
    qv = ~qv;
    tick(qv, ~qv, 1'b1);
    check("coll_cnt", toggle_cnt, 0);
    check("coll_t", t_out, 1);
    check("coll_burst", burst, 0);
    tff(1'b1);
    tff(1'b1);
    check("coll_run2_burst", burst, 0);
    tff(1'b1);
    check("coll_run3_burst", burst, 1);

    // clear colliding with a fault sample
    tick(qv, qv, 1'b1);
    check("clr_err_coll", err, 0);
    check("clr_err_burst", burst, 0);

    // reset mid-burst
    for (int i = 0; i < 3; i++) tff(1'b1);
    check("pre_rst_burst", burst, 1);
    rst = 1'b1;
    #1;
    check_zero("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    tick(qv, ~qv, 1'b0);
    check("post_rst_t", t_out, int'(qv));
    check("post_rst_cnt", toggle_cnt, int'(qv));
`else
    q_in = 1'b0; qn_in = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tick(1'b0, 1'b1, 1'b0);
    check("sync_mask1_err", err, 0);
    tick(1'b0, 1'b1, 1'b0);
    check("sync_mask2_err", err, 0);
    tick(1'b1, 1'b0, 1'b0);
    check("sync_lat1_t", t_out, 0);
    tick(1'b1, 1'b0, 1'b0);
    check("sync_lat2_t", t_out, 0);
    tick(1'b1, 1'b0, 1'b0);
    check("sync_lat3_t", t_out, 1);
    tick(1'b1, 1'b0, 1'b0);
    check("sync_lat4_t", t_out, 0);
    check("sync_err", err, 0);
`endif

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
